// File: rtl/gp_shreg_sr.sv
// rtl/gp_shreg_sr.sv - WIDTH x DEPTH delay line with two inverting taps, set/reset fill and fill counter
module gp_shreg_sr #(
  parameter int   WIDTH    = 1,
  parameter int   DEPTH    = 16,
  parameter int   TAP_A    = DEPTH - 1,
  parameter int   TAP_B    = 0,
  parameter logic INIT     = 1'b0,
  parameter logic SRMODE   = 1'b0,
  parameter logic INVERT_A = 1'b0,
  parameter logic INVERT_B = 1'b0,
  localparam int  FW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             SR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [FW-1:0]    FILL,
  output logic             FULL
);

  // Out-of-range parameters stop elaboration rather than being clamped.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("gp_shreg_sr: WIDTH %0d outside 1..16", WIDTH);
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("gp_shreg_sr: DEPTH %0d outside 2..256", DEPTH);
  end
  if (TAP_A < 0 || TAP_A > DEPTH - 1) begin : g_bad_tap_a
    $error("gp_shreg_sr: TAP_A %0d outside 0..DEPTH-1", TAP_A);
  end
  if (TAP_B < 0 || TAP_B > DEPTH - 1) begin : g_bad_tap_b
    $error("gp_shreg_sr: TAP_B %0d outside 0..DEPTH-1", TAP_B);
  end

  localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
  localparam logic [WIDTH-1:0] INIT_W   = {WIDTH{INIT}};
  localparam logic [WIDTH-1:0] SR_W     = {WIDTH{SRMODE}};
  localparam logic [WIDTH-1:0] INV_A_W  = {WIDTH{INVERT_A}};
  localparam logic [WIDTH-1:0] INV_B_W  = {WIDTH{INVERT_B}};

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;

  // SR beats CE; RST is handled in the register process and beats both.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (SR) begin
      for (int k = 0; k < DEPTH; k++) stage_d[k] = SR_W;
      fill_d = '0;
    end else if (CE) begin
      stage_d[0] = D;
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= INIT_W;
      fill_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
      fill_q <= fill_d;
    end
  end

  assign QA   = stage_q[TAP_A] ^ INV_A_W;
  assign QB   = stage_q[TAP_B] ^ INV_B_W;
  assign FILL = fill_q;
  assign FULL = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_gp_shreg_sr.sv
// tb/tb_gp_shreg_sr.sv - directed bench for gp_shreg_sr (WIDTH=4, DEPTH=8, taps 7/2, INIT=0, SRMODE=1, QB inverted)
module tb_gp_shreg_sr;

  logic       clk = 1'b0;
  logic       rst, ce, sr;
  logic [3:0] d;
  logic [3:0] qa, qb;
  logic [3:0] fill;
  logic       full;

  int compared   = 0;
  int mismatched = 0;

  gp_shreg_sr #(
    .WIDTH(4), .DEPTH(8), .TAP_A(7), .TAP_B(2),
    .INIT(1'b0), .SRMODE(1'b1), .INVERT_A(1'b0), .INVERT_B(1'b1)
  ) dut (
    .CLK(clk), .RST(rst), .CE(ce), .SR(sr), .D(d),
    .QA(qa), .QB(qb), .FILL(fill), .FULL(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic c, input logic [3:0] dv);
    rst = r; sr = s; ce = c; d = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sr = 1'b0; ce = 1'b1; d = 4'hF;

    // Reset held two edges with CE=1, D=F
    step(1, 0, 1, 4'hF);
    step(1, 0, 1, 4'hF);
    check("rst_qa",   {12'b0, qa},   16'h0);
    check("rst_qb",   {12'b0, qb},   16'hF);
    check("rst_fill", {12'b0, fill}, 16'h0);
    check("rst_full", {15'b0, full}, 16'h0);

    // Latency: D=5 on edge 1, zeros afterwards
    step(0, 0, 1, 4'h5);
    step(0, 0, 1, 4'h0);
    check("lat_qb_e2", {12'b0, qb}, 16'hF);
    step(0, 0, 1, 4'h0);
    check("lat_qb_e3",   {12'b0, qb},   16'hA);
    check("lat_fill_e3", {12'b0, fill}, 16'h3);
    for (int i = 4; i <= 7; i++) step(0, 0, 1, 4'h0);
    check("lat_qa_e7",   {12'b0, qa},   16'h0);
    check("lat_full_e7", {15'b0, full}, 16'h0);
    step(0, 0, 1, 4'h0);
    check("lat_qa_e8",   {12'b0, qa},   16'h5);
    check("lat_fill_e8", {12'b0, fill}, 16'h8);
    check("lat_full_e8", {15'b0, full}, 16'h1);
    for (int i = 9; i <= 12; i++) step(0, 0, 1, 4'h0);
    check("sat_fill_e12", {12'b0, fill}, 16'h8);
    check("sat_full_e12", {15'b0, full}, 16'h1);
    check("sat_qa_e12",   {12'b0, qa},   16'h0);

    // SR beats CE with pipe full
    step(0, 1, 1, 4'h3);
    check("sr_qa",   {12'b0, qa},   16'hF);
    check("sr_qb",   {12'b0, qb},   16'h0);
    check("sr_fill", {12'b0, fill}, 16'h0);
    check("sr_full", {15'b0, full}, 16'h0);
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 4'h0);
    check("sr_qa_e7", {12'b0, qa}, 16'hF);
    step(0, 0, 1, 4'h0);
    check("sr_qa_e8",   {12'b0, qa},   16'h0);
    check("sr_fill_e8", {12'b0, fill}, 16'h8);

    // CE gating: load 5, then CE 1,0,0,1
    step(1, 0, 0, 4'h0);
    check("rst2_fill", {12'b0, fill}, 16'h0);
    step(0, 0, 1, 4'h5);
    step(0, 0, 1, 4'h0);
    check("ce_qb_1", {12'b0, qb}, 16'hF);
    step(0, 0, 0, 4'h0);
    check("ce_qb_2", {12'b0, qb}, 16'hF);
    step(0, 0, 0, 4'h7);
    check("ce_qb_3",   {12'b0, qb},   16'hF);
    check("ce_fill_3", {12'b0, fill}, 16'h2);
    step(0, 0, 1, 4'h0);
    check("ce_qb_4",   {12'b0, qb},   16'hA);
    check("ce_fill_4", {12'b0, fill}, 16'h3);

    // Reset mid-operation after 5 CE edges, with SR and CE also high
    step(0, 0, 1, 4'h9);
    step(0, 0, 1, 4'h9);
    check("mid_fill5", {12'b0, fill}, 16'h5);
    step(1, 1, 1, 4'hF);
    check("mid_qa",   {12'b0, qa},   16'h0);
    check("mid_qb",   {12'b0, qb},   16'hF);
    check("mid_fill", {12'b0, fill}, 16'h0);
    check("mid_full", {15'b0, full}, 16'h0);
    step(0, 0, 1, 4'h6);
    check("post_qa",   {12'b0, qa},   16'h0);
    check("post_qb",   {12'b0, qb},   16'hF);
    check("post_fill", {12'b0, fill}, 16'h1);
    step(0, 0, 1, 4'h0);
    step(0, 0, 1, 4'h0);
    check("post_qb_e3", {12'b0, qb}, 16'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
